// File: rtl/pri_arb_pkg.sv
// pri_arb_pkg: shared types and sizes for the fixed-priority arbiter
package pri_arb_pkg;
  localparam int NUM_REQ = 16;
  localparam int ID_W = 4;
  localparam int HOLD_W = 4;
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  function automatic logic [NUM_REQ-1:0] id2onehot(input logic [ID_W-1:0] id);
    return NUM_REQ'(1) << id;
  endfunction
endpackage

// File: rtl/pri_enc16.sv
// pri_enc16: lowest-set-index priority encoder, bit 0 highest priority
module pri_enc16
  import pri_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] din,
  output logic [ID_W-1:0]    idx,
  output logic               valid
);
  always_comb begin
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) idx = din[i] ? ID_W'(i) : idx;
  end
  assign valid = |din;
endmodule

// File: rtl/pri_arbiter_ctrl.sv
// pri_arbiter_ctrl: fixed-priority arbiter with hold limit, one-cycle gap and timeout masking
module pri_arbiter_ctrl
  import pri_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_id,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic               timeout
);
  localparam logic [HOLD_W-1:0] MAX_C = HOLD_W'(MAX_HOLD);
  state_t state, state_n;
  logic [HOLD_W-1:0] cnt, cnt_n;
  logic [NUM_REQ-1:0] mask, mask_n, oh_n;
  logic [ID_W-1:0] id_n, win;
  logic win_v, gv_n, to_n, hold_req, limit;
  pri_enc16 u_enc (
    .din  (req & ~mask),
    .idx  (win),
    .valid(win_v)
  );
  assign hold_req = req[grant_id];
  assign limit = cnt == MAX_C;
  always_comb begin
    state_n = state;
    id_n = grant_id;
    cnt_n = cnt;
    mask_n = mask;
    gv_n = grant_valid;
    oh_n = grant_onehot;
    to_n = 1'b0;
    case (state)
      IDLE: begin
        mask_n = '0;
        if (enable && win_v) begin
          state_n = GRANT;
          id_n = win;
          cnt_n = HOLD_W'(1);
          gv_n = 1'b1;
          oh_n = id2onehot(win);
        end
      end
      GRANT: begin
        if (!enable || !hold_req || limit) begin
          state_n = GAP;
          id_n = '0;
          cnt_n = '0;
          gv_n = 1'b0;
          oh_n = '0;
          // only a pure hold-limit exit counts as a timeout and masks the holder
          to_n = enable && hold_req;
          mask_n = (enable && hold_req) ? id2onehot(grant_id) : mask;
        end else begin
          cnt_n = cnt + HOLD_W'(1);
        end
      end
      GAP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      mask <= '0;
      grant_valid <= 1'b0;
      grant_id <= '0;
      grant_onehot <= '0;
      timeout <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      mask <= mask_n;
      grant_valid <= gv_n;
      grant_id <= id_n;
      grant_onehot <= oh_n;
      timeout <= to_n;
    end
  end
endmodule

// File: tb/tb_pri_arbiter_ctrl.sv
// tb_pri_arbiter_ctrl: directed and random checks against a behavioural arbiter model
module tb_pri_arbiter_ctrl;
  localparam int MH = 8;
  logic clk = 1'b0;
  logic rst_n, enable;
  logic [15:0] req;
  logic grant_valid, timeout;
  logic [3:0] grant_id;
  logic [15:0] grant_onehot;
  int n_chk = 0;
  int n_fail = 0;
  int ph;
  int mid;
  int mhold;
  logic [15:0] mmask;
  logic mto;
  always #5 clk = ~clk;
  pri_arbiter_ctrl #(.MAX_HOLD(MH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .req         (req),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .grant_onehot(grant_onehot),
    .timeout     (timeout)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int lowest(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return -1;
  endfunction
  task automatic model_reset();
    ph = 0;
    mid = 0;
    mhold = 0;
    mmask = '0;
    mto = 1'b0;
  endtask
  // phase 0 = waiting, 1 = someone holds the grant, 2 = mandatory gap
  task automatic model_edge();
    int w;
    if (ph == 0) begin
      w = lowest(req & ~mmask);
      mmask = '0;
      mto = 1'b0;
      if (enable && w >= 0) begin
        ph = 1;
        mid = w;
        mhold = 1;
      end
    end else if (ph == 1) begin
      if (!req[mid] || !enable) begin
        ph = 2;
        mto = 1'b0;
      end else if (mhold == MH) begin
        ph = 2;
        mto = 1'b1;
        mmask = 16'(1) << mid;
      end else begin
        mhold++;
      end
    end else begin
      ph = 0;
      mto = 1'b0;
    end
  endtask
  task automatic cmp_all(input string tag);
    chk({tag, ".valid"}, 32'(grant_valid), 32'(ph == 1));
    chk({tag, ".id"}, 32'(grant_id), ph == 1 ? 32'(mid) : 32'd0);
    chk({tag, ".onehot"}, 32'(grant_onehot), ph == 1 ? 32'(1) << mid : 32'd0);
    chk({tag, ".timeout"}, 32'(timeout), 32'(mto));
  endtask
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cmp_all(tag);
  endtask
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    cmp_all(tag);
    #1 rst_n = 1'b1;
  endtask
  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    req = '0;
    model_reset();
    #12;
    cmp_all("rst");
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 10; i++) step("idle0");
    req = 16'h8010;
    step("p27a");
    chk("p27_id4", 32'(grant_id), 32'd4);
    chk("p27_oh", 32'(grant_onehot), 32'h0010);
    step("p27b");
    req = 16'h8000;
    step("p27gap");
    chk("p27_gap", 32'(grant_valid), 32'd0);
    step("p27idle");
    step("p27c");
    chk("p27_id15", 32'(grant_id), 32'd15);
    req = 16'h0000;
    step("p27d");
    step("p27e");
    req = 16'h0003;
    for (int i = 0; i < 45; i++) step("p28");
    req = 16'h0000;
    step("p28r");
    step("p28r");
    req = 16'h0080;
    step("p29a");
    chk("p29_id7", 32'(grant_id), 32'd7);
    enable = 1'b0;
    step("p29b");
    chk("p29_drop", 32'(grant_valid), 32'd0);
    for (int i = 0; i < 5; i++) step("p29c");
    enable = 1'b1;
    step("p29d");
    req = 16'h0000;
    for (int i = 0; i < 3; i++) step("p30pre");
    req = 16'h0020;
    step("p30a");
    step("p30b");
    async_reset("p30rst");
    req = 16'h0100;
    step("p30c");
    chk("p30_id8", 32'(grant_id), 32'd8);
    req = 16'h0000;
    for (int i = 0; i < 3; i++) step("p31pre");
    req = 16'h0004;
    for (int i = 0; i < MH; i++) step("p31hold");
    req = 16'h0000;
    step("p31gap");
    chk("p31_to", 32'(timeout), 32'd0);
    req = 16'h0004;
    step("p31idle");
    step("p31regrant");
    chk("p31_nomask", 32'(grant_id), 32'd2);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0)
        req = 16'($urandom) & 16'($urandom) & 16'($urandom);
      enable = $urandom_range(0, 24) != 0;
      if ($urandom_range(0, 799) == 0) async_reset("rnd_rst");
      step("rnd");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
